pattern_stim_misr: RTL and testbench

Self-test harness for the graph-grammar benchmark netlists. It drives pseudo-random input vectors into a merged-pattern test circuit and compacts that circuit's responses into a signature. A 16-bit Galois LFSR supplies the stimulus, and a 16-bit MISR compresses the responses. A start/done handshake sequences each run. When a run finishes, the signature is compared against a golden value, giving a pass/fail verdict without per-vector checking.

---
 rtl/pattern_stim_misr.sv | 166 ++++++++++++++++
 tb/tb_pattern_stim_misr.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_stim_misr.sv
// pattern_stim_misr: LFSR stimulus source plus MISR response compactor
// for self-testing the merged-pattern benchmark netlists.
// Ports: blif_clk_net / blif_reset_net (async, active-high) clock and reset;
//   start, seed, num_vec, golden   run control (num_vec taken on start,
//                                  golden taken in DONE);
//   stim_out, stim_valid           registered stimulus to the netlist;
//   dut_resp                       netlist response, LAT cycles behind;
//   busy, done, signature, pass    run status and verdict.

module pattern_stim_misr #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 11,
  parameter int CNT_W = 16,
  parameter int LAT   = 2
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             start,
  input  logic [15:0]      seed,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [15:0]      golden,
  output logic [IN_W-1:0]  stim_out,
  output logic             stim_valid,
  input  logic [OUT_W-1:0] dut_resp,
  output logic             busy,
  output logic             done,
  output logic [15:0]      signature,
  output logic             pass
);

  localparam logic [15:0] POLY = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      misr_q, misr_d;
  logic [15:0]      sig_q, sig_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [3:0]       drn_q, drn_d;
  logic             pass_q, pass_d;
  logic             cap_en;
  logic [15:0]      resp_ext;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? POLY : 16'h0000);
  endfunction

  assign stim_out   = lfsr_q[IN_W-1:0];
  assign stim_valid = (state_q == S_RUN);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign signature  = sig_q;
  assign pass       = pass_q;

  always_comb begin
    resp_ext = '0;
    resp_ext[OUT_W-1:0] = dut_resp;
  end

  // cap_en marks the cycle a response to an applied vector arrives
  generate
    if (LAT == 0) begin : g_nolat
      assign cap_en = stim_valid;
    end else begin : g_lat
      logic [LAT-1:0] pipe_q, pipe_d;

      always_comb begin
        pipe_d    = pipe_q << 1;
        pipe_d[0] = stim_valid;
        if (state_q == S_SEED) begin
          pipe_d = '0;
        end
      end

      always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
        if (blif_reset_net) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign cap_en = pipe_q[LAT-1];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    vec_d   = vec_q;
    drn_d   = drn_q;
    sig_d   = sig_q;
    pass_d  = pass_q;

    if (cap_en) begin
      misr_d = lfsr_step(misr_q) ^ resp_ext;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d   = num_vec;
          state_d = S_SEED;
        end
      end
      S_SEED: begin
        lfsr_d  = (seed == 16'h0000) ? 16'h0001 : seed;
        misr_d  = '0;
        state_d = (vec_q != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        lfsr_d = lfsr_step(lfsr_q);
        vec_d  = vec_q - CNT_W'(1);
        // drain counts down LAT-1..0, giving LAT cycles in DRAIN
        drn_d  = 4'(LAT - 1);
        if (vec_q == CNT_W'(1)) begin
          state_d = (LAT == 0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drn_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          drn_d = drn_q - 4'd1;
        end
      end
      S_DONE: begin
        sig_d   = misr_q;
        pass_d  = (misr_q == golden);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state_q <= S_IDLE;
      lfsr_q  <= 16'h0001;
      misr_q  <= '0;
      vec_q   <= '0;
      drn_q   <= '0;
      sig_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      vec_q   <= vec_d;
      drn_q   <= drn_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

endmodule

// File: tb/tb_pattern_stim_misr.sv
// tb_pattern_stim_misr: directed and random runs on three instances
// (LAT 2, 0, 5) against a behavioural signature model.

module tb_pattern_stim_misr;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  start_a;
  logic [15:0] seed, golden, num_vec;
  logic [15:0] resp_a [3];
  logic [15:0] stim0, stim1;
  logic [10:0] stim2, resp2;
  logic [15:0] sig0, sig1, sig2;
  logic [2:0]  valid_a, busy_a, done_a, pass_a;
  logic [15:0] stim_a [3];
  logic [15:0] sig_a [3];

  assign resp2 = resp_a[2][10:0];

  always_comb begin
    stim_a[0] = stim0;
    stim_a[1] = stim1;
    stim_a[2] = {5'b0, stim2};
    sig_a[0]  = sig0;
    sig_a[1]  = sig1;
    sig_a[2]  = sig2;
  end

  pattern_stim_misr #(.IN_W(16), .OUT_W(16), .CNT_W(16), .LAT(2)) u0 (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start_a[0]),
    .seed(seed), .num_vec(num_vec), .golden(golden),
    .stim_out(stim0), .stim_valid(valid_a[0]), .dut_resp(resp_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .signature(sig0), .pass(pass_a[0])
  );

  pattern_stim_misr #(.IN_W(16), .OUT_W(16), .CNT_W(16), .LAT(0)) u1 (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start_a[1]),
    .seed(seed), .num_vec(num_vec), .golden(golden),
    .stim_out(stim1), .stim_valid(valid_a[1]), .dut_resp(resp_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .signature(sig1), .pass(pass_a[1])
  );

  pattern_stim_misr #(.IN_W(11), .OUT_W(11), .CNT_W(16), .LAT(5)) u2 (
    .blif_clk_net(clk), .blif_reset_net(rst), .start(start_a[2]),
    .seed(seed), .num_vec(num_vec), .golden(golden),
    .stim_out(stim2), .stim_valid(valid_a[2]), .dut_resp(resp2),
    .busy(busy_a[2]), .done(done_a[2]), .signature(sig2), .pass(pass_a[2])
  );

  int lat_a [3] = '{2, 0, 5};
  int inw_a [3] = '{16, 16, 11};
  int outw_a [3] = '{16, 16, 11};

  int checks = 0;
  int errors = 0;

  bit          active = 1'b0;
  int          sel = 0;
  int          cur_c = 0;
  logic        exp_valid, exp_busy, exp_done;
  logic [15:0] exp_stim;
  int          vcnt, dcnt, done_c;
  logic [15:0] obs [$];
  logic [15:0] hist [16];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] gstep(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] wmask(input int w);
    return 16'((32'd1 << w) - 1);
  endfunction

  // per-cycle compare of the selected instance, plus a stim history
  // used to emulate a netlist that delays stim_out by LAT cycles
  always @(negedge clk) begin
    for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = stim_a[sel];
    if (active) begin
      chk("stim_valid", {15'b0, valid_a[sel]}, {15'b0, exp_valid});
      chk("busy", {15'b0, busy_a[sel]}, {15'b0, exp_busy});
      chk("done", {15'b0, done_a[sel]}, {15'b0, exp_done});
      if (exp_valid) chk("stim_out", stim_a[sel], exp_stim);
      if (valid_a[sel]) begin
        vcnt++;
        obs.push_back(stim_a[sel]);
      end
      if (done_a[sel]) begin
        dcnt++;
        if (done_c < 0) done_c = cur_c;
      end
    end
  end

  // mode 0: random responses, 1: LAT-delayed stim_out, 2: constant cval
  task automatic run(input int si, input logic [15:0] sd, input int n,
                     input logic [15:0] gold, input bit gmodel,
                     input int mode, input logic [15:0] cval,
                     input int restart_c, input int rst_c,
                     output logic [15:0] sig_out,
                     output logic [15:0] msig);
    logic [15:0] s [$];
    logic [15:0] r [$];
    logic [15:0] v, m, mi, mo, g, rv;
    int L, D, idx;
    L  = lat_a[si];
    mi = wmask(inw_a[si]);
    mo = wmask(outw_a[si]);
    v  = (sd == 16'h0) ? 16'h0001 : sd;
    for (int k = 0; k < n; k++) begin
      s.push_back(v);
      v = gstep(v);
    end
    for (int k = 0; k < n; k++) begin
      if (mode == 1) r.push_back(s[k] & mi & mo);
      else if (mode == 2) r.push_back(cval & mo);
      else r.push_back(16'($urandom) & mo);
    end
    m = 16'h0;
    for (int k = 0; k < n; k++) m = gstep(m) ^ r[k];
    msig = m;
    g = gmodel ? m : gold;
    D = (n == 0) ? 2 : n + L + 2;

    sel = si;
    cur_c = 0;
    exp_valid = 1'b0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_stim = 16'h0;
    vcnt = 0;
    dcnt = 0;
    done_c = -1;
    obs.delete();
    seed = sd;
    num_vec = 16'(n);
    golden = g;
    start_a[si] = 1'b1;
    active = 1'b1;
    @(posedge clk);
    #1;
    start_a[si] = 1'b0;
    for (int c = 1; c <= D + 1; c++) begin
      cur_c = c;
      exp_busy = (c <= D);
      exp_done = (c == D);
      exp_valid = (n > 0) && (c >= 2) && (c <= n + 1);
      exp_stim = exp_valid ? (s[c-2] & mi) : 16'h0;
      idx = c - 2 - L;
      if (mode == 1) rv = (L == 0) ? stim_a[si] : hist[L-1];
      else if (mode == 2) rv = cval;
      else if (idx >= 0 && idx < n) rv = r[idx];
      else rv = 16'($urandom);
      resp_a[si] = rv;
      start_a[si] = (c == restart_c);
      if (c == rst_c) begin
        active = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_valid", {15'b0, valid_a[si]}, 16'h0);
        chk("abort_busy", {15'b0, busy_a[si]}, 16'h0);
        chk("abort_done", {15'b0, done_a[si]}, 16'h0);
        chk("abort_sig", sig_a[si], 16'h0);
        @(negedge clk);
        rst = 1'b0;
        start_a[si] = 1'b0;
        @(posedge clk);
        #1;
        sig_out = sig_a[si];
        return;
      end
      if (c == D + 1) begin
        chk("signature", sig_a[si], m);
        chk("pass", {15'b0, pass_a[si]}, {15'b0, (m == g)});
      end
      @(posedge clk);
      #1;
    end
    active = 1'b0;
    sig_out = sig_a[si];
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not reach its end");
    $fatal(1, "watchdog");
  end

  logic [15:0] rsig, msig, msig_ref, sd_r, gd_r;
  int si_r, n_r, md_r;
  bit gm_r;

  initial begin
    start_a = '0;
    seed = '0;
    golden = '0;
    num_vec = '0;
    for (int i = 0; i < 3; i++) resp_a[i] = '0;
    for (int i = 0; i < 16; i++) hist[i] = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_stim", stim_a[i], 16'h0001);
      chk("rst_valid", {15'b0, valid_a[i]}, 16'h0);
      chk("rst_busy", {15'b0, busy_a[i]}, 16'h0);
      chk("rst_done", {15'b0, done_a[i]}, 16'h0);
      chk("rst_sig", sig_a[i], 16'h0);
      chk("rst_pass", {15'b0, pass_a[i]}, 16'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // seed 0, three vectors, zero responses
    run(0, 16'h0000, 3, 16'h0000, 1'b0, 2, 16'h0000, 0, 0, rsig, msig);
    chk("t1_nvec", 16'(vcnt), 16'd3);
    if (obs.size() >= 3) begin
      chk("t1_v0", obs[0], 16'h0001);
      chk("t1_v1", obs[1], 16'hB400);
      chk("t1_v2", obs[2], 16'h5A00);
    end
    chk("t1_done_c", 16'(done_c), 16'd7);
    chk("t1_sig", rsig, 16'h0000);
    chk("t1_pass", {15'b0, pass_a[0]}, 16'h0001);

    // single vector, LAT 0, constant response 1
    run(1, 16'h0001, 1, 16'h0001, 1'b0, 2, 16'h0001, 0, 0, rsig, msig);
    chk("t2_sig", rsig, 16'h0001);
    chk("t2_pass1", {15'b0, pass_a[1]}, 16'h0001);
    chk("t2_done_c", 16'(done_c), 16'd3);
    run(1, 16'h0001, 1, 16'h0002, 1'b0, 2, 16'h0001, 0, 0, rsig, msig);
    chk("t2_pass0", {15'b0, pass_a[1]}, 16'h0000);

    // zero vectors
    run(0, 16'h1234, 0, 16'h0000, 1'b0, 0, 16'h0, 0, 0, rsig, msig);
    chk("t3_done_c", 16'(done_c), 16'd2);
    chk("t3_nvec", 16'(vcnt), 16'd0);
    chk("t3_sig", rsig, 16'h0000);
    chk("t3_pass", {15'b0, pass_a[0]}, 16'h0001);

    // start pulsed during RUN, and during DONE
    run(0, 16'hBEEF, 5, 16'h0, 1'b1, 0, 16'h0, 4, 0, rsig, msig);
    chk("t4_nvec", 16'(vcnt), 16'd5);
    chk("t4_ndone", 16'(dcnt), 16'd1);
    run(0, 16'hBEEF, 5, 16'h0, 1'b1, 0, 16'h0, 9, 0, rsig, msig);
    chk("t4b_ndone", 16'(dcnt), 16'd1);
    chk("t4b_idle", {15'b0, busy_a[0]}, 16'h0);

    // reset in the third RUN cycle, then a fresh identical run
    run(0, 16'hACE1, 5, 16'h0, 1'b1, 1, 16'h0, 0, 0, rsig, msig_ref);
    run(0, 16'hACE1, 5, 16'h0, 1'b1, 1, 16'h0, 0, 4, rsig, msig);
    chk("t5_ndone", 16'(dcnt), 16'd0);
    run(0, 16'hACE1, 5, 16'h0, 1'b1, 1, 16'h0, 0, 0, rsig, msig);
    chk("t5_rerun_sig", rsig, msig_ref);

    for (int it = 0; it < 1000; it++) begin
      si_r = $urandom_range(0, 2);
      sd_r = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      n_r  = $urandom_range(0, 16);
      md_r = $urandom_range(0, 1);
      gm_r = 1'($urandom_range(0, 1));
      gd_r = 16'($urandom);
      run(si_r, sd_r, n_r, gd_r, gm_r, md_r, 16'h0, 0, 0, rsig, msig);
      chk("rnd_ndone", 16'(dcnt), 16'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
